// File: rtl/jericalla_pkg.sv
// Shared constants for the Jericalla execution datapath: widths, ALU op codes,
// instruction field positions and the fixed constant-ROM contents.
package jericalla_pkg;

  localparam int WORD  = 32;
  localparam int ADDR  = 4;
  localparam int INSTR = 17;
  localparam int OPW   = 4;

  localparam logic [OPW-1:0] OP_AND = 4'd0;
  localparam logic [OPW-1:0] OP_OR  = 4'd1;
  localparam logic [OPW-1:0] OP_ADD = 4'd2;
  localparam logic [OPW-1:0] OP_SUB = 4'd6;
  localparam logic [OPW-1:0] OP_SLT = 4'd7;
  localparam logic [OPW-1:0] OP_NOR = 4'd12;

  localparam int RAM_ADDR_HI = 16;
  localparam int RAM_ADDR_LO = 13;
  localparam int OP_HI       = 12;
  localparam int OP_LO       = 9;
  localparam int ROMA_HI     = 8;
  localparam int ROMA_LO     = 5;
  localparam int ROMB_HI     = 4;
  localparam int ROMB_LO     = 1;
  localparam int EN_BIT      = 0;

  // ROM word i holds the value i, zero-extended
  function automatic logic [WORD-1:0] rom_word(input logic [ADDR-1:0] addr);
    return {{(WORD-ADDR){1'b0}}, addr};
  endfunction

endpackage

// File: rtl/jericalla_alu.sv
// Combinational 32-bit ALU of the Jericalla datapath; undefined op codes
// yield a zero result, so their zero flag is set.
module jericalla_alu
  import jericalla_pkg::*;
(
  input  logic [WORD-1:0] a,
  input  logic [WORD-1:0] b,
  input  logic [OPW-1:0]  op,
  output logic [WORD-1:0] res,
  output logic            zero
);

  // Operation select and zero detect
  always_comb begin
    res = {WORD{1'b0}};
    case (op)
      OP_AND:  res = a & b;
      OP_OR:   res = a | b;
      OP_ADD:  res = a + b;
      OP_SUB:  res = a - b;
      OP_SLT:  res = (a < b) ? {{(WORD-1){1'b0}}, 1'b1} : {WORD{1'b0}};
      OP_NOR:  res = ~(a | b);
      default: res = {WORD{1'b0}};
    endcase
    zero = (res == {WORD{1'b0}});
  end

endmodule

// File: rtl/jericalla_datapath.sv
// Jericalla execution core: two ROM operands feed the ALU, whose result is
// either stored into the 16-word RAM or replaced on the output by a RAM read.
module jericalla_datapath
  import jericalla_pkg::*;
(
  input  logic             clk,
  input  logic             rst_n,
  input  logic [INSTR-1:0] instruccion,
  output logic [WORD-1:0]  salida,
  output logic             zflag
);

  logic [ADDR-1:0] ram_addr_s;
  logic [OPW-1:0]  op_s;
  logic [ADDR-1:0] rom_a_addr_s;
  logic [ADDR-1:0] rom_b_addr_s;
  logic            en_s;
  logic [WORD-1:0] a_s;
  logic [WORD-1:0] b_s;
  logic [WORD-1:0] res_s;
  logic            zero_s;

  logic [WORD-1:0] ram_r [16];
  logic [WORD-1:0] salida_r;
  logic            zflag_r;

  assign ram_addr_s   = instruccion[RAM_ADDR_HI:RAM_ADDR_LO];
  assign op_s         = instruccion[OP_HI:OP_LO];
  assign rom_a_addr_s = instruccion[ROMA_HI:ROMA_LO];
  assign rom_b_addr_s = instruccion[ROMB_HI:ROMB_LO];
  assign en_s         = instruccion[EN_BIT];

  assign a_s = rom_word(rom_a_addr_s);
  assign b_s = rom_word(rom_b_addr_s);

  jericalla_alu u_alu (
    .a    (a_s),
    .b    (b_s),
    .op   (op_s),
    .res  (res_s),
    .zero (zero_s)
  );

  // RAM write or read-out, zero-flag capture; reset clears every RAM word
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      salida_r <= {WORD{1'b0}};
      zflag_r  <= 1'b0;
      for (int i = 0; i < 16; i++) begin
        ram_r[i] <= {WORD{1'b0}};
      end
    end else begin
      zflag_r <= zero_s;
      if (en_s) begin
        ram_r[ram_addr_s] <= res_s;
      end else begin
        salida_r <= ram_r[ram_addr_s];
      end
    end
  end

  assign salida = salida_r;
  assign zflag  = zflag_r;

endmodule

// File: tb/tb_jericalla_datapath.sv
// Directed, table-driven bench for jericalla_datapath with hand-computed
// expectations, plus hand-written reset sequences.
module tb_jericalla_datapath;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [16:0] instruccion;
  logic [31:0] salida;
  logic        zflag;

  int tests_run = 0;
  int tests_failed = 0;

  jericalla_datapath dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .instruccion (instruccion),
    .salida      (salida),
    .zflag       (zflag)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [16:0] instr;
    logic [31:0] exp_salida;
    logic        exp_zflag;
  } vec_t;

  vec_t vecs [22];

  function automatic logic [16:0] enc(input int addr, input int op, input int a,
                                      input int b, input int en);
    logic [3:0] ad4;
    logic [3:0] op4;
    logic [3:0] a4;
    logic [3:0] b4;
    logic       en1;
    ad4 = addr[3:0];
    op4 = op[3:0];
    a4  = a[3:0];
    b4  = b[3:0];
    en1 = en[0];
    return {ad4, op4, a4, b4, en1};
  endfunction

  task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests_run++;
    if (act !== exp) begin
      tests_failed++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic check1(input string name, input logic act, input logic exp);
    tests_run++;
    if (act !== exp) begin
      tests_failed++;
      $display("FAIL %s: got %b, expected %b", name, act, exp);
    end
  endtask

  // Present an instruction, let one rising edge pass, sample 1 time unit later
  task automatic step(input logic [16:0] instr);
    instruccion = instr;
    @(posedge clk);
    #1;
  endtask

  initial begin
    // {instr, expected salida, expected zflag} after the edge that samples instr
    vecs[0]  = '{enc(5, 0, 0, 0, 0),   32'd0,          1'b1}; // read RAM[5] after reset
    vecs[1]  = '{enc(2, 2, 4, 6, 1),   32'd0,          1'b0}; // RAM[2] <= 4+6
    vecs[2]  = '{enc(2, 0, 0, 0, 0),   32'd10,         1'b1}; // read RAM[2]
    vecs[3]  = '{enc(7, 6, 3, 3, 1),   32'd10,         1'b1}; // RAM[7] <= 3-3
    vecs[4]  = '{enc(7, 0, 0, 0, 0),   32'd0,          1'b1};
    vecs[5]  = '{enc(3, 7, 2, 5, 1),   32'd0,          1'b0}; // RAM[3] <= 2<5
    vecs[6]  = '{enc(4, 12, 0, 0, 1),  32'd0,          1'b0}; // RAM[4] <= ~(0|0)
    vecs[7]  = '{enc(3, 1, 1, 0, 0),   32'd1,          1'b0}; // read RAM[3], OR res 1
    vecs[8]  = '{enc(4, 0, 0, 0, 0),   32'hFFFF_FFFF,  1'b1};
    vecs[9]  = '{enc(2, 15, 9, 4, 1),  32'hFFFF_FFFF,  1'b1}; // undefined op stores 0
    vecs[10] = '{enc(2, 2, 9, 4, 0),   32'd0,          1'b0}; // RAM[2] now 0; ADD res 13
    vecs[11] = '{enc(9, 0, 13, 7, 1),  32'd0,          1'b0}; // RAM[9] <= 13&7 = 5
    vecs[12] = '{enc(10, 6, 2, 5, 1),  32'd0,          1'b0}; // RAM[10] <= 2-5
    vecs[13] = '{enc(11, 7, 5, 2, 1),  32'd0,          1'b1}; // RAM[11] <= 5<2 = 0
    vecs[14] = '{enc(9, 1, 8, 4, 0),   32'd5,          1'b0};
    vecs[15] = '{enc(10, 7, 5, 5, 0),  32'hFFFF_FFFD,  1'b1};
    vecs[16] = '{enc(11, 2, 15, 15, 0), 32'd0,         1'b0};
    vecs[17] = '{enc(15, 2, 15, 15, 1), 32'd0,         1'b0}; // RAM[15] <= 30
    vecs[18] = '{enc(15, 0, 0, 0, 0),  32'd30,         1'b1};
    vecs[19] = '{enc(0, 12, 15, 15, 0), 32'd0,         1'b0}; // read RAM[0], NOR res nonzero
    vecs[20] = '{enc(6, 2, 7, 8, 0),   32'd0,          1'b0}; // read must not write res
    vecs[21] = '{enc(6, 0, 0, 0, 0),   32'd0,          1'b1};

    // Initial reset for 2 cycles, with an instruction whose zero flag would be 1
    rst_n = 1'b0;
    instruccion = enc(5, 15, 0, 0, 0);
    @(posedge clk);
    @(posedge clk);
    #1;
    check32("reset_salida", salida, 32'd0);
    check1("reset_zflag", zflag, 1'b0);
    rst_n = 1'b1;

    for (int i = 0; i < 22; i++) begin
      step(vecs[i].instr);
      check32($sformatf("vec%0d_salida", i), salida, vecs[i].exp_salida);
      check1($sformatf("vec%0d_zflag", i), zflag, vecs[i].exp_zflag);
    end

    // Reset mid-operation: store 10 in RAM[2], put 30 on salida, then reset
    // while a write to RAM[12] is presented
    step(enc(2, 2, 4, 6, 1));
    step(enc(15, 0, 0, 0, 0));
    check32("pre_reset_salida", salida, 32'd30);
    rst_n = 1'b0;
    step(enc(12, 2, 1, 1, 1));
    check32("midreset_salida", salida, 32'd0);
    check1("midreset_zflag", zflag, 1'b0);
    rst_n = 1'b1;
    step(enc(2, 0, 0, 0, 0));
    check32("post_reset_ram2", salida, 32'd0);
    step(enc(15, 0, 0, 0, 0));
    check32("post_reset_ram15", salida, 32'd0);
    step(enc(12, 2, 1, 1, 0));
    check32("reset_beats_write_ram12", salida, 32'd0);
    check1("post_reset_zflag_add", zflag, 1'b0);

    // Back-to-back write then read of the same address
    step(enc(12, 2, 1, 1, 1));
    step(enc(12, 6, 1, 1, 0));
    check32("b2b_readback", salida, 32'd2);
    check1("b2b_zflag", zflag, 1'b1);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
